// File: rtl/sub_shift_serial.sv
// Byte-serial AES SubBytes + ShiftRows: one combinational S-box is time-shared
// over the 16 state bytes, so a result is ready 16 cycles after accept.
module sub_shift_serial #(
    parameter bit SHIFT_EN = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q;
    logic [3:0]     cnt_q;
    logic [127:0]   src_q;
    logic [127:0]   res_q;
    logic           out_valid_q;

    logic [7:0]     sbox_in_d;
    logic [7:0]     sbox_out_d;
    logic [3:0]     dst_idx_d;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^254 == 0 for x == 0, as AES requires).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] b;
        b = gf_inv(x);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    // Source byte select, substitution and ShiftRows destination for this cycle.
    always_comb begin
        sbox_in_d  = src_q[{~cnt_q, 3'b000} +: 8];
        sbox_out_d = aes_sbox(sbox_in_d);
        dst_idx_d  = SHIFT_EN ? {cnt_q[3:2] - cnt_q[1:0], cnt_q[1:0]} : cnt_q;
    end

    // Control FSM, byte counter and state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            src_q       <= 128'd0;
            res_q       <= 128'd0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        src_q   <= in_state;
                        cnt_q   <= 4'd0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    res_q[{~dst_idx_d, 3'b000} +: 8] <= sbox_out_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // in_ready is gated by rst so upstream never sees a ready while reset is held.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = out_valid_q;
    assign out_state = res_q;

endmodule

// File: tb/tb_sub_shift_serial.sv
// Randomized self-checking bench for sub_shift_serial (both SHIFT_EN settings)
// against a table-driven AES SubBytes/ShiftRows reference model.
module tb_sub_shift_serial;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [127:0] in_state;
    logic         out_ready;
    logic         in_ready1, out_valid1, in_ready0, out_valid0;
    logic [127:0] out_state1, out_state0;

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0] sbox_tab [256];

    always #5 clk = ~clk;

    sub_shift_serial #(.SHIFT_EN(1'b1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .in_state(in_state), .out_valid(out_valid1), .out_ready(out_ready),
        .out_state(out_state1)
    );

    sub_shift_serial #(.SHIFT_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .in_state(in_state), .out_valid(out_valid0), .out_ready(out_ready),
        .out_state(out_state0)
    );

    // GF(2^8) product: carry-less multiply, then reduce modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = 15'd0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (15'h011b << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (ref_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    // out[r][c] = S(in[r][(c+r) mod 4]) with ShiftRows, else out[i] = S(in[i]).
    function automatic logic [127:0] model(input logic [127:0] st, input bit shift);
        logic [127:0] o;
        int r, c, src;
        for (int i = 0; i < 16; i++) begin
            r = i % 4;
            c = i / 4;
            src = shift ? r + 4 * ((c + r) % 4) : i;
            o[127 - 8 * i -: 8] = sbox_tab[st[127 - 8 * src -: 8]];
        end
        return o;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    // Wait for ready, accept one state, scramble the input, wait for out_valid.
    task automatic do_txn(input logic [127:0] st, output logic [127:0] got1,
                          output logic [127:0] got0, output int lat);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_state = st;
        while (!in_ready1 && w < 50) begin step(); w++; end
        step();
        in_valid = 1'b0;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid1 && lat < 40) begin step(); lat++; end
        got1 = out_state1;
        got0 = out_state0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_state = '0; out_ready = 1'b0;
        repeat (3) step();
        n_checks++; if (in_ready1 !== 1'b0) $display("FAIL reset_in_ready got %b want 0", in_ready1); else n_pass++;
        n_checks++; if (out_valid1 !== 1'b0 || out_valid0 !== 1'b0) $display("FAIL reset_out_valid got %b%b want 00", out_valid1, out_valid0); else n_pass++;
        n_checks++; if (out_state1 !== 128'd0) $display("FAIL reset_out_state got %h want 0", out_state1); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (in_ready1 !== 1'b1 || in_ready0 !== 1'b1) $display("FAIL reset_release_in_ready got %b%b want 11", in_ready1, in_ready0); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        int seen;
        in_valid = 1'b1;
        in_state = {$urandom, $urandom, $urandom, $urandom};
        step();
        in_valid = 1'b0;
        repeat (5) step();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid1 !== 1'b0) $display("FAIL midrun_out_valid got %b want 0", out_valid1); else n_pass++;
        n_checks++; if (out_state1 !== 128'd0 || out_state0 !== 128'd0) $display("FAIL midrun_out_state got %h want 0", out_state1); else n_pass++;
        n_checks++; if (in_ready1 !== 1'b1) $display("FAIL midrun_in_ready got %b want 1", in_ready1); else n_pass++;
        seen = 0;
        repeat (20) begin step(); if (out_valid1 || out_valid0) seen++; end
        n_checks++; if (seen !== 0) $display("FAIL midrun_no_output got %0d valid cycles want 0", seen); else n_pass++;
    endtask

    task automatic test_known();
        logic [127:0] vin [3];
        logic [127:0] v1 [3];
        logic [127:0] v0 [3];
        logic [127:0] g1, g0;
        int lat;
        vin[0] = 128'h0;
        v1[0]  = 128'h63636363636363636363636363636363;
        v0[0]  = 128'h63636363636363636363636363636363;
        vin[1] = 128'h000102030405060708090a0b0c0d0e0f;
        v1[1]  = 128'h636b6776f201ab7b30d777c5fe7c6f2b;
        v0[1]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        vin[2] = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        v1[2]  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        v0[2]  = model(vin[2], 1'b0);
        for (int k = 0; k < 3; k++) begin
            do_txn(vin[k], g1, g0, lat);
            n_checks++; if (lat !== 16) $display("FAIL known%0d_latency got %0d want 16", k, lat); else n_pass++;
            n_checks++; if (g1 !== v1[k]) $display("FAIL known%0d_shift got %h want %h", k, g1, v1[k]); else n_pass++;
            n_checks++; if (g0 !== v0[k]) $display("FAIL known%0d_noshift got %h want %h", k, g0, v0[k]); else n_pass++;
            handshake();
        end
    endtask

    task automatic test_random();
        logic [127:0] st, g1, g0;
        int lat;
        for (int k = 0; k < 8; k++) begin
            st = {$urandom, $urandom, $urandom, $urandom};
            do_txn(st, g1, g0, lat);
            n_checks++; if (lat !== 16) $display("FAIL rand%0d_latency got %0d want 16", k, lat); else n_pass++;
            n_checks++; if (g1 !== model(st, 1'b1)) $display("FAIL rand%0d_shift got %h want %h", k, g1, model(st, 1'b1)); else n_pass++;
            n_checks++; if (g0 !== model(st, 1'b0)) $display("FAIL rand%0d_noshift got %h want %h", k, g0, model(st, 1'b0)); else n_pass++;
            handshake();
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] st, st2, g1, g0, exp1;
        int lat, bad;
        st = {$urandom, $urandom, $urandom, $urandom};
        exp1 = model(st, 1'b1);
        do_txn(st, g1, g0, lat);
        bad = 0;
        repeat (10) begin
            in_valid = ~in_valid;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            step();
            if (out_state1 !== exp1 || in_ready1 !== 1'b0 || out_valid1 !== 1'b1) bad++;
        end
        in_valid = 1'b0;
        n_checks++; if (bad !== 0) $display("FAIL bp_hold got %0d bad cycles want 0", bad); else n_pass++;
        handshake();
        n_checks++; if (out_valid1 !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", out_valid1); else n_pass++;
        st2 = {$urandom, $urandom, $urandom, $urandom};
        do_txn(st2, g1, g0, lat);
        n_checks++; if (g1 !== model(st2, 1'b1)) $display("FAIL bp_next got %h want %h", g1, model(st2, 1'b1)); else n_pass++;
        // Handshake and rst in the same cycle: rst must win and clear outputs.
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (out_valid1 !== 1'b0 || out_state1 !== 128'd0) $display("FAIL rst_vs_handshake got %b %h want 0 0", out_valid1, out_state1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [127:0] sts [4];
        logic [127:0] r1 [$];
        logic [127:0] r0 [$];
        int acc [4];
        int k, cyc;
        for (int i = 0; i < 4; i++) sts[i] = {$urandom, $urandom, $urandom, $urandom};
        k = 0;
        cyc = 0;
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (r1.size() < 4 && cyc < 200) begin
            if (k < 4) begin
                in_state = sts[k];
                if (in_ready1) begin acc[k] = cyc; k++; end
            end else begin
                in_valid = 1'b0;
            end
            step();
            cyc++;
            if (out_valid1) begin r1.push_back(out_state1); r0.push_back(out_state0); end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_checks++; if (r1.size() !== 4) $display("FAIL b2b_count got %0d want 4", r1.size()); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            n_checks++; if (k < 4 || acc[i] - acc[i-1] !== 18) $display("FAIL b2b_interval%0d got %0d want 18", i, acc[i] - acc[i-1]); else n_pass++;
        end
        for (int i = 0; i < 4 && i < r1.size(); i++) begin
            n_checks++; if (r1[i] !== model(sts[i], 1'b1)) $display("FAIL b2b%0d_shift got %h want %h", i, r1[i], model(sts[i], 1'b1)); else n_pass++;
            n_checks++; if (r0[i] !== model(sts[i], 1'b0)) $display("FAIL b2b%0d_noshift got %h want %h", i, r0[i], model(sts[i], 1'b0)); else n_pass++;
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_known();
        test_random();
        test_backpressure();
        test_reset_mid_run();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired after %0d/%0d checks", n_pass, n_checks);
        $fatal(1);
    end

endmodule
